// File: rtl/modinv.sv
// Modular inverse a^-1 mod P, P = 2^24-3, using the binary extended Euclidean algorithm.
// Start/done handshake: start is a request sampled only in IDLE; done pulses for one cycle with result/err valid; no backpressure.
module modinv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] a,
  output logic [23:0] result,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  state_dbg
);

  localparam logic [23:0] P = 24'hFFFFFD;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic [23:0] a_q;
  logic [23:0] u;
  logic [23:0] v;
  logic [23:0] x1;
  logic [23:0] x2;
  logic [23:0] ar;

  assign ar        = (a_q >= P) ? a_q - P : a_q;
  assign state_dbg = state;

  // Halving mod P: odd values get P added (25-bit) so the shift stays exact.
  function automatic logic [23:0] half_mod(input logic [23:0] x);
    logic [24:0] s;
    s = {1'b0, x} + {1'b0, P};
    if (x[0]) return s[24:1];
    else      return {1'b0, x[23:1]};
  endfunction

  function automatic logic [23:0] sub_mod(input logic [23:0] x, input logic [23:0] y);
    logic [24:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[24]) return d[23:0] + P;
    else       return d[23:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      a_q    <= '0;
      u      <= '0;
      v      <= '0;
      x1     <= '0;
      x2     <= '0;
      result <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (ar == 24'd0) begin
            result <= '0;
            err    <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (ar == 24'd1) begin
            result <= 24'd1;
            err    <= 1'b0;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            u     <= ar;
            v     <= P;
            x1    <= 24'd1;
            x2    <= 24'd0;
            state <= RUN;
          end
        end
        RUN: begin
          // Invariants: x1*ar == u and x2*ar == v (mod P).
          if (u == 24'd1) begin
            result <= x1;
            err    <= 1'b0;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (v == 24'd1) begin
            result <= x2;
            err    <= 1'b0;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (!u[0]) begin
            u  <= {1'b0, u[23:1]};
            x1 <= half_mod(x1);
          end else if (!v[0]) begin
            v  <= {1'b0, v[23:1]};
            x2 <= half_mod(x2);
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= sub_mod(x1, x2);
          end else begin
            v  <= v - u;
            x2 <= sub_mod(x2, x1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modinv.sv
// Self-checking bench for modinv: scoreboard of expected {err,result} against an exponentiation model.
module tb_modinv;

  localparam logic [23:0] P = 24'hFFFFFD;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] a;
  logic [23:0] result;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  state_dbg;

  logic [24:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  modinv dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Fermat: a^(P-2) mod P, independent of the Euclidean datapath.
  function automatic logic [23:0] pow_mod(input logic [23:0] b, input logic [23:0] e);
    longint unsigned r, base, ee;
    r = 1;
    base = {40'd0, b} % {40'd0, P};
    ee = {40'd0, e};
    while (ee != 0) begin
      if (ee[0]) r = (r * base) % {40'd0, P};
      base = (base * base) % {40'd0, P};
      ee = ee >> 1;
    end
    return r[23:0];
  endfunction

  function automatic logic [24:0] model(input logic [23:0] val);
    logic [23:0] r;
    r = val % P;
    if (r == 24'd0) return {1'b1, 24'd0};
    return {1'b0, pow_mod(r, P - 24'd2)};
  endfunction

  // Waits (from a negedge) for done; lat counts rising edges since the accepting edge (inclusive).
  task automatic wait_done(input int lat_in, output int lat, output logic got,
                           output logic saw_done_state, output logic busy_in_done);
    lat = lat_in;
    got = 1'b0;
    saw_done_state = 1'b0;
    busy_in_done = 1'b0;
    while (!got && lat < 120) begin
      if (state_dbg == 2'd3) begin
        saw_done_state = 1'b1;
        busy_in_done = busy_in_done | busy | done;
      end
      if (done) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_op(input string name, input logic [23:0] val, input int exact_lat);
    int lat;
    logic got, sds, bid;
    logic [24:0] exp;
    longint unsigned prod;
    @(negedge clk);
    a = val;
    start = 1'b1;
    exp_q.push_back(model(val));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat, got, sds, bid);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: no done after %0d cycles, required <=100", name, lat);
      exp_q.delete();
      return;
    end
    exp = exp_q.pop_front();
    total++;
    if ({err, result} !== exp) begin
      bad++;
      $display("FAIL %s value: a=%h got err=%b result=%h, required err=%b result=%h",
               name, val, err, result, exp[24], exp[23:0]);
    end
    total++;
    if (exact_lat > 0 ? (lat != exact_lat) : (lat > 100)) begin
      bad++;
      $display("FAIL %s latency: a=%h got %0d, required %s%0d", name, val, lat,
               exact_lat > 0 ? "" : "<=", exact_lat > 0 ? exact_lat : 100);
    end
    if (!exp[24]) begin
      prod = ({40'd0, val % P} * {40'd0, result}) % {40'd0, P};
      total++;
      if (prod != 64'd1) begin
        bad++;
        $display("FAIL %s product: a=%h result=%h a*result mod P=%0d, required 1", name, val, result, prod);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_width: done=%b one cycle after pulse, required 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    a = 24'd0;
    repeat (2) @(negedge clk);
    total++;
    if ({result, err, done, busy, state_dbg} !== 29'd0) begin
      bad++;
      $display("FAIL reset_state: result=%h err=%b done=%b busy=%b state=%0d, required all 0",
               result, err, done, busy, state_dbg);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op("inv_2", 24'h000002, 0);
    run_op("inv_pm1", 24'hFFFFFC, 0);
    run_op("inv_1", 24'h000001, 3);
    run_op("inv_3", 24'h000003, 0);
  endtask

  task automatic test_shortcut();
    run_op("short_fffffe", 24'hFFFFFE, 3);
    run_op("wrap_ffffff", 24'hFFFFFF, 0);
  endtask

  task automatic test_err();
    run_op("err_zero", 24'h000000, 3);
    run_op("err_p", 24'hFFFFFD, 3);
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 100; i++) run_op("sweep", 24'hF0F0F0 + 24'(i), 0);
    for (int i = 0; i < 10; i++) run_op("random", 24'($urandom_range(2, 24'hFFFFFC)), 0);
  endtask

  task automatic test_reset_mid_run();
    logic seen_done;
    @(negedge clk);
    a = 24'h123457;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (state_dbg !== 2'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_in_run: state=%0d busy=%b, required 2 and 1", state_dbg, busy);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({result, err, done, busy, state_dbg} !== 29'd0) begin
      bad++;
      $display("FAIL midrst_async: result=%h err=%b done=%b busy=%b state=%0d, required all 0",
               result, err, done, busy, state_dbg);
    end
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (110) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_no_done: done seen=%b after abort, required 0", seen_done);
    end
    run_op("after_reset", 24'h000002, 0);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic got, sds, bid;
    logic [24:0] exp;
    logic [23:0] a1, a2;
    a1 = 24'h00ABCD;
    a2 = 24'h765432;
    @(negedge clk);
    a = a1;
    start = 1'b1;
    exp_q.push_back(model(a1));
    exp_q.push_back(model(a2));
    @(posedge clk);
    repeat (3) @(negedge clk);
    a = a2;
    total++;
    if (state_dbg !== 2'd2) begin
      bad++;
      $display("FAIL b2b_in_run: state=%0d when a changed, required 2", state_dbg);
    end
    wait_done(3, lat, got, sds, bid);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL b2b_first timeout: no done after %0d cycles", lat);
      exp_q.delete();
      start = 1'b0;
      return;
    end
    exp = exp_q.pop_front();
    total++;
    if ({err, result} !== exp) begin
      bad++;
      $display("FAIL b2b_first value: got err=%b result=%h, required err=%b result=%h",
               err, result, exp[24], exp[23:0]);
    end
    total++;
    if (!sds || bid) begin
      bad++;
      $display("FAIL b2b_done_state: DONE seen=%b busy/done in DONE=%b, required 1 and 0", sds, bid);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_restart: busy=%b done=%b edge after done, required 1 and 0", busy, done);
    end
    wait_done(2, lat, got, sds, bid);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL b2b_second timeout: no done after %0d cycles", lat);
      exp_q.delete();
      return;
    end
    exp = exp_q.pop_front();
    total++;
    if ({err, result} !== exp) begin
      bad++;
      $display("FAIL b2b_second value: got err=%b result=%h, required err=%b result=%h",
               err, result, exp[24], exp[23:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shortcut();
    test_err();
    test_sweep();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
